// File: rtl/snake_game_sched.sv
// Game-step scheduler for the GreedySnake BSRAM demo.
// A prescaled tick paces the game: each step issues one move request to the
// list-update engine, waits for it, then one render request to the map reader.
// Direction keys are filtered against the committed direction, and the
// reader's game-over flag stops play until the next start.
module snake_game_sched #(
   parameter logic [23:0] TICK_DIV     = 24'd6_750_000,
   parameter logic [15:0] BUSY_TIMEOUT = 16'd4095,
   parameter logic [1:0]  INIT_DIR     = 2'd1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        pause,
   input  logic        dir_valid,
   input  logic [1:0]  dir_in,
   output logic        mv_init,
   output logic        mv_en,
   output logic [1:0]  mv_dir,
   input  logic        mv_busy,
   output logic        rd_en,
   input  logic        rd_busy,
   input  logic        rd_game_over,
   output logic        game_over,
   output logic        sched_err,
   output logic [7:0]  tick_overrun,
   output logic [15:0] step_cnt
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_INIT_REQ,
      S_INIT_WAIT,
      S_WAIT_TICK,
      S_MV_REQ,
      S_MV_WAIT,
      S_RD_REQ,
      S_RD_WAIT,
      S_OVER
   } state_t;

   state_t      state;
   logic [23:0] presc;
   logic        tick_pending;
   logic [15:0] wait_cnt;
   logic [1:0]  dir_pend;
   logic        moved;

   logic running;
   logic in_wait;
   logic tick;
   logic consume;
   logic wait_busy;
   logic released;
   logic timed_out;
   logic key_ok;

   // Decode tick, busy release/timeout and key acceptance from current state
   always_comb begin
      running   = (state != S_IDLE) && (state != S_OVER);
      in_wait   = (state == S_INIT_WAIT) || (state == S_MV_WAIT) || (state == S_RD_WAIT);
      tick      = running && !pause && (presc == TICK_DIV - 24'd1);
      consume   = (state == S_WAIT_TICK) && tick_pending && !pause;
      wait_busy = (state == S_RD_WAIT) ? rd_busy : mv_busy;
      // busy is not trusted on the first wait cycle: the sub-block may not have raised it yet
      released  = in_wait && (wait_cnt != 16'd0) && !wait_busy;
      timed_out = in_wait && !released && (wait_cnt == BUSY_TIMEOUT);
      // a key that would reverse the committed direction by 180 degrees is dropped
      key_ok    = dir_valid && ((dir_in ^ mv_dir) != 2'b10);
   end

   // Step sequencer, prescaler, direction filter and status counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         presc        <= '0;
         tick_pending <= 1'b0;
         wait_cnt     <= '0;
         dir_pend     <= INIT_DIR;
         moved        <= 1'b0;
         mv_init      <= 1'b0;
         mv_en        <= 1'b0;
         mv_dir       <= INIT_DIR;
         rd_en        <= 1'b0;
         game_over    <= 1'b0;
         sched_err    <= 1'b0;
         tick_overrun <= '0;
         step_cnt     <= '0;
      end else begin
         mv_init  <= 1'b0;
         mv_en    <= 1'b0;
         rd_en    <= 1'b0;
         wait_cnt <= wait_cnt + 16'd1;

         if (running && !pause)
            presc <= tick ? 24'd0 : presc + 24'd1;

         // a new tick lands after the old one is consumed; only an unconsumed one overruns
         tick_pending <= (tick_pending && !consume) || tick;
         if (tick && tick_pending && !consume && (tick_overrun != 8'hFF))
            tick_overrun <= tick_overrun + 8'd1;

         if (key_ok)
            dir_pend <= dir_in;

         if (timed_out)
            sched_err <= 1'b1;

         case (state)
            S_IDLE, S_OVER: begin
               if (start) begin
                  state        <= S_INIT_REQ;
                  mv_init      <= 1'b1;
                  mv_dir       <= INIT_DIR;
                  dir_pend     <= INIT_DIR;
                  step_cnt     <= '0;
                  tick_pending <= 1'b0;
                  presc        <= '0;
                  game_over    <= 1'b0;
                  moved        <= 1'b0;
               end
            end
            S_INIT_REQ: begin
               state    <= S_INIT_WAIT;
               wait_cnt <= '0;
            end
            S_INIT_WAIT, S_MV_WAIT: begin
               if (released || timed_out) begin
                  state <= S_RD_REQ;
                  rd_en <= 1'b1;
               end
            end
            S_WAIT_TICK: begin
               if (consume) begin
                  state  <= S_MV_REQ;
                  mv_en  <= 1'b1;
                  mv_dir <= dir_pend;
                  moved  <= 1'b1;
               end
            end
            S_MV_REQ: begin
               state    <= S_MV_WAIT;
               wait_cnt <= '0;
            end
            S_RD_REQ: begin
               state    <= S_RD_WAIT;
               wait_cnt <= '0;
            end
            S_RD_WAIT: begin
               if (released || timed_out) begin
                  if (moved)
                     step_cnt <= step_cnt + 16'd1;
                  moved <= 1'b0;
                  // on timeout the reader's flag is not trusted
                  if (released && rd_game_over) begin
                     state     <= S_OVER;
                     game_over <= 1'b1;
                  end else begin
                     state <= S_WAIT_TICK;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
